// File: rtl/seq_detector_pkg.sv
// Shared types and width helpers for the multi-pattern sequence detector.
// Used by the interface, the lane sub-module and the top (optional counters: SEQDET_COUNT_EN).
package seq_detector_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        ACTIVE = 1'b1
    } seq_state_e;

    localparam logic [0:0] ST_HUNT   = HUNT;
    localparam logic [0:0] ST_ACTIVE = ACTIVE;

    // Width of cfg_len: must hold 0..PAT_MAX.
    function automatic int len_w(input int pat_max);
        return $clog2(pat_max + 32'sd1);
    endfunction

    // Width of cfg_sel, never narrower than one bit.
    function automatic int sel_w(input int num_pat);
        return (num_pat > 32'sd1) ? $clog2(num_pat) : 32'sd1;
    endfunction

    // Fill counter saturates at PAT_MAX, so it shares the length width.
    function automatic int fill_w(input int pat_max);
        return $clog2(pat_max + 32'sd1);
    endfunction

endpackage

// File: rtl/seq_detector_multi_if.sv
// Symbol/config/result bundle of seq_detector_multi; cnt_clr and match_cnt
// exist only when SEQDET_COUNT_EN is defined.
interface seq_detector_multi_if
    import seq_detector_pkg::*;
#(
    parameter int SYM_W   = 2,
    parameter int PAT_MAX = 4,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8
) ();
    localparam int LEN_W = len_w(PAT_MAX);
    localparam int SEL_W = sel_w(NUM_PAT);

    logic                       in_valid;
    logic [SYM_W-1:0]           in_sym;
    logic                       cfg_we;
    logic [SEL_W-1:0]           cfg_sel;
    logic [PAT_MAX*SYM_W-1:0]   cfg_pat;
    logic [LEN_W-1:0]           cfg_len;
    logic                       cfg_ovl;
    logic                       active;
    logic [NUM_PAT-1:0]         match;
`ifdef SEQDET_COUNT_EN
    logic                       cnt_clr;
    logic [NUM_PAT*CNT_W-1:0]   match_cnt;

    modport master (
        output in_valid, in_sym, cfg_we, cfg_sel, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        input  active, match, match_cnt
    );
    modport slave (
        input  in_valid, in_sym, cfg_we, cfg_sel, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        output active, match, match_cnt
    );
`else
    modport master (
        output in_valid, in_sym, cfg_we, cfg_sel, cfg_pat, cfg_len, cfg_ovl,
        input  active, match
    );
    modport slave (
        input  in_valid, in_sym, cfg_we, cfg_sel, cfg_pat, cfg_len, cfg_ovl,
        output active, match
    );
`endif

endinterface

// File: rtl/seq_detector_lane.sv
// One pattern lane: config registers, fill counter, compare, match pulse and
// (with SEQDET_COUNT_EN) a saturating match counter.
module seq_detector_lane
    import seq_detector_pkg::*;
#(
    parameter int SYM_W   = 2,
    parameter int PAT_MAX = 4,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = len_w(PAT_MAX),
    localparam int FILL_W = fill_w(PAT_MAX)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_acc,
    input  logic                     flush,
    input  logic [PAT_MAX*SYM_W-1:0] hist_nxt,
    input  logic                     cfg_we,
    input  logic [PAT_MAX*SYM_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_ovl,
`ifdef SEQDET_COUNT_EN
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         match_cnt,
`endif
    output logic                     match
);
    localparam logic [FILL_W-1:0] PAT_MAX_F = FILL_W'(PAT_MAX);
    localparam logic [LEN_W-1:0]  PAT_MAX_L = LEN_W'(PAT_MAX);
    localparam logic [FILL_W-1:0] ONE_F     = FILL_W'(32'd1);

    logic [PAT_MAX*SYM_W-1:0] pat_r;
    logic [LEN_W-1:0]         len_r;
    logic                     ovl_r;
    logic [FILL_W-1:0]        fill_r;
    logic                     match_r;
    logic [FILL_W-1:0]        fill_inc_s;
    logic [LEN_W-1:0]         len_clamp_s;
    logic                     eq_s;
    logic                     hit_s;

    // Saturating fill increment and clamped length for a config write.
    always_comb begin
        fill_inc_s  = fill_r;
        len_clamp_s = cfg_len;
        if (fill_r >= PAT_MAX_F) begin
            fill_inc_s = PAT_MAX_F;
        end else begin
            fill_inc_s = fill_r + ONE_F;
        end
        if (cfg_len > PAT_MAX_L) begin
            len_clamp_s = PAT_MAX_L;
        end else begin
            len_clamp_s = cfg_len;
        end
    end

    // Newest history symbol lines up with the last pattern symbol.
    always_comb begin
        eq_s = 1'b1;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(len_r)) begin
                if (hist_nxt[i*SYM_W +: SYM_W] != pat_r[(int'(len_r) - 32'sd1 - i)*SYM_W +: SYM_W]) begin
                    eq_s = 1'b0;
                end else begin
                    eq_s = eq_s;
                end
            end else begin
                eq_s = eq_s;
            end
        end
        hit_s = data_acc && (len_r != {LEN_W{1'b0}}) && (FILL_W'(len_r) <= fill_inc_s) && eq_s;
    end

    // Config, fill and match state; the accepted symbol is judged on the old config.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_r   <= {(PAT_MAX*SYM_W){1'b0}};
            len_r   <= {LEN_W{1'b0}};
            ovl_r   <= 1'b0;
            fill_r  <= {FILL_W{1'b0}};
            match_r <= 1'b0;
        end else begin
            match_r <= hit_s;
            if (cfg_we) begin
                pat_r  <= cfg_pat;
                len_r  <= len_clamp_s;
                ovl_r  <= cfg_ovl;
                fill_r <= {FILL_W{1'b0}};
            end else if (flush) begin
                fill_r <= {FILL_W{1'b0}};
            end else if (data_acc && (len_r != {LEN_W{1'b0}})) begin
                if (hit_s && !ovl_r) begin
                    fill_r <= {FILL_W{1'b0}};
                end else begin
                    fill_r <= fill_inc_s;
                end
            end else begin
                fill_r <= fill_r;
            end
        end
    end

    assign match = match_r;

`ifdef SEQDET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating match counter; a clear beats a same-edge increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (hit_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign match_cnt = cnt_r;
`endif

endmodule

// File: rtl/seq_detector_multi.sv
// Multi-pattern symbol sequence detector: hunt/lock FSM, shared history and
// NUM_PAT lanes. Optional per-lane match counters with SEQDET_COUNT_EN.
module seq_detector_multi
    import seq_detector_pkg::*;
#(
    parameter int SYM_W     = 2,
    parameter int PAT_MAX   = 4,
    parameter int NUM_PAT   = 2,
    parameter int SYNC_SYM  = 2,
    parameter int ABORT_SYM = 3,
    parameter int CNT_W     = 8,
    localparam int SEL_W    = sel_w(NUM_PAT),
    localparam int HIST_W   = (PAT_MAX - 1) * SYM_W
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_detector_multi_if.slave bus
);
    localparam logic [SYM_W-1:0] SYNC_V  = SYM_W'(SYNC_SYM);
    localparam logic [SYM_W-1:0] ABORT_V = SYM_W'(ABORT_SYM);

    logic [0:0]               state_r;
    // Only PAT_MAX-1 older symbols are stored; the incoming one completes the window.
    logic [HIST_W-1:0]        hist_r;
    logic [PAT_MAX*SYM_W-1:0] hist_nxt_s;
    logic                     sync_s;
    logic                     abort_s;
    logic                     data_acc_s;
    logic [NUM_PAT-1:0]       match_s;

    // Classify the incoming symbol against the current FSM state.
    always_comb begin
        sync_s     = bus.in_valid && (state_r == ST_HUNT)   && (bus.in_sym == SYNC_V);
        abort_s    = bus.in_valid && (state_r == ST_ACTIVE) && (bus.in_sym == ABORT_V);
        data_acc_s = bus.in_valid && (state_r == ST_ACTIVE) && (bus.in_sym != ABORT_V);
        hist_nxt_s = {hist_r, bus.in_sym};
    end

    // Hunt/lock state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    if (sync_s) begin
                        state_r <= ST_ACTIVE;
                    end else begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_ACTIVE: begin
                    if (abort_s) begin
                        state_r <= ST_HUNT;
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                default: state_r <= ST_HUNT;
            endcase
        end
    end

    // Shared history: shifts on data symbols, wiped on abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_r <= {HIST_W{1'b0}};
        end else if (abort_s) begin
            hist_r <= {HIST_W{1'b0}};
        end else if (data_acc_s) begin
            hist_r <= hist_nxt_s[HIST_W-1:0];
        end else begin
            hist_r <= hist_r;
        end
    end

    assign bus.active = (state_r == ST_ACTIVE);
    assign bus.match  = match_s;

`ifdef SEQDET_COUNT_EN
    logic [NUM_PAT*CNT_W-1:0] cnt_s;
    assign bus.match_cnt = cnt_s;
`endif

    for (genvar p = 0; p < NUM_PAT; p++) begin : g_lane
        logic lane_we_s;
        assign lane_we_s = bus.cfg_we && (bus.cfg_sel == SEL_W'(p));

        seq_detector_lane #(
            .SYM_W   (SYM_W),
            .PAT_MAX (PAT_MAX),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .data_acc  (data_acc_s),
            .flush     (abort_s),
            .hist_nxt  (hist_nxt_s),
            .cfg_we    (lane_we_s),
            .cfg_pat   (bus.cfg_pat),
            .cfg_len   (bus.cfg_len),
            .cfg_ovl   (bus.cfg_ovl),
`ifdef SEQDET_COUNT_EN
            .cnt_clr   (bus.cnt_clr),
            .match_cnt (cnt_s[p*CNT_W +: CNT_W]),
`endif
            .match     (match_s[p])
        );
    end

endmodule

// File: doc/seq_detector_multi.md
# seq_detector_multi

Parametrised multi-pattern symbol-sequence detector. It watches a stream of SYM_W-bit symbols and flags completion of up to NUM_PAT independently programmable patterns, each up to PAT_MAX symbols long. A hunt/lock front end ignores traffic until a sync symbol arrives and drops back to hunting on an abort symbol. It sits between the symbol source and the control logic that reacts to detected command sequences.

## Interface
- SYM_W, 2, symbol width in bits
- PAT_MAX, 4, maximum pattern length in symbols (≥2)
- NUM_PAT, 2, number of independent pattern lanes (≥1)
- SYNC_SYM, 2, symbol that moves HUNT→ACTIVE; must differ from ABORT_SYM
- ABORT_SYM, 3, symbol that moves ACTIVE→HUNT
- CNT_W, 8, per-lane match counter width
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- in_valid  in  1  in_sym is sampled on a clock edge only when high
- in_sym  in  SYM_W  input symbol
- cfg_we  in  1  pattern write strobe
- cfg_sel  in  $clog2(NUM_PAT) (min 1)  lane being written
- cfg_pat  in  PAT_MAX*SYM_W  pattern; slice [SYM_W-1:0] is the first (oldest) symbol
- cfg_len  in  $clog2(PAT_MAX+1)  pattern length; 0 disables the lane; values >PAT_MAX are clamped to PAT_MAX
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  in  1  clears all match counters (only with SEQDET_COUNT_EN)
- active  out  1  1 while the FSM is in ACTIVE
- match  out  NUM_PAT  one-cycle pulse per lane on completion
- match_cnt  out  NUM_PAT*CNT_W  saturating per-lane counters (only with SEQDET_COUNT_EN)

## Operation
- FSM states: HUNT, ACTIVE. Reset → HUNT.
- HUNT: a valid SYNC_SYM → ACTIVE; the symbol is consumed and not written to history. All other symbols are ignored.
- ACTIVE: a valid ABORT_SYM → HUNT; history and all fill counts cleared; no match. Any other valid symbol, including SYNC_SYM, is data: it is shifted into history (hist[0] = newest, PAT_MAX deep) and every enabled lane's fill is incremented, saturating at PAT_MAX.
- Lane p matches on an accepted data symbol when, after the shift, fill[p] ≥ len[p] and hist[i] == pat[p][len-1-i] for all i < len[p].
- On a match: with ovl=1, fill is kept, so suffix overlap is allowed; with ovl=0, fill[p] is cleared to 0.
- Lanes are independent; several may match on the same symbol.
- in_valid low: no state, history, or fill change.
- Config write: lane cfg_sel takes pat, len, and ovl at the edge, and its fill is cleared. The symbol accepted on that same edge is evaluated against the old config, and its match pulse, if any, still issues. The history buffer itself is not affected.
- Reset values: state HUNT, active=0, match=0, history=0, all fills=0, all len=0 (lanes disabled), pat=0, ovl=0, match_cnt=0.

## Timing
- Latency is 1: a symbol accepted at edge k drives match[p]=1 during cycle k+1, for exactly one cycle.
- active updates on the same edge as the transition.
- Back-to-back valid symbols are supported every cycle with no stall. There is no ready signal.
- rst_n low at an edge overrides all other inputs, including one mid-pattern. A pulse already on match is cleared at that edge.

## Configuration
- SEQDET_COUNT_EN defined: adds cnt_clr and match_cnt.
  - Each lane's counter increments on its match, one cycle after the symbol, together with the pulse, and saturates at 2^CNT_W-1.
  - cnt_clr wins over a simultaneous increment, giving a result of 0.
- SEQDET_COUNT_EN undefined: the ports are absent, and no counter logic is present.

## Structure
- Package seq_detector_pkg holds the FSM state enum (HUNT, ACTIVE) and shared localparams: the width helpers for cfg_len, cfg_sel, and fill.
- Sub-module seq_detector_lane holds one lane's pattern, length, and overlap registers, fill counter, compare logic, match register, and optional counter. It is instantiated NUM_PAT times by a generate loop.
- The top holds the FSM and the shared history shift register.

## Test plan
- Default parameters. Lane 0 = {2,0,1,1} (len 4, ovl 0). Send 2 (sync), then 2,0,1,1 → active=1 after the first symbol; match[0] pulses once, the cycle after the final 1.
- Lane 1 = {1,1} (len 2, ovl 1). In ACTIVE, send 1,1,1 → match[1] pulses twice, in consecutive cycles. With ovl 0, the same stimulus gives one pulse.
- Send 2,0,3,1,1 → abort at 3 gives active=0. The trailing 1,1 is ignored, with no match, until another 2 is sent.
- In HUNT, send 0,1,1 → no match and active stays 0. Asserting rst_n=0 mid-pattern (after 2,0) clears everything; completing the pattern afterwards gives no match.
- Write lane 0 on the same edge as the final pattern symbol → the old-config match still pulses, fill clears, and the next symbol cannot complete the old pattern.
- With SEQDET_COUNT_EN and CNT_W=2: 5 matches → match_cnt saturates at 3. cnt_clr concurrent with a match → 0.
